// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment encoding for the 7-segment scan driver.
// Segment codes are active-low gfedcba; the top applies board polarity.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    ON
  } scan_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational nibble to active-low gfedcba segment lookup.
// Zero latency; no flow control.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex display driver: double-buffered digits, guard time, LZ blanking, blink.
// All pin outputs registered one clock after the scan state; no backpressure, loads always accepted.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_DIV    = 25000000,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_blank_lz,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - GUARD_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (GUARD_CYCLES < 0 || SCAN_DIV <= GUARD_CYCLES) begin : g_bad_scan_div
    $error("seg7_scan_driver: need 0 <= GUARD_CYCLES < SCAN_DIV");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("seg7_scan_driver: BLINK_DIV must be >= 1");
  end

  scan_state_t               state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BLK_W-1:0]          blink_cnt_q, blink_cnt_d;
  logic                      blink_vis_q, blink_vis_d;
  logic [4*NUM_DIGITS-1:0]   act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]     act_blk_q, act_blk_d, pend_blk_q, pend_blk_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_done_q, frame_done_d;

  logic                      wrap;
  logic [3:0]                nib;
  logic                      dp_bit, blk_bit, upper_nz, show, hide;
  logic [NUM_DIGITS-1:0]     an_hot;
  logic [6:0]                lut_seg, seg_al;

  always_comb begin : fsm
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!i_enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = (GUARD_CYCLES == 0) ? ON : GUARD;
          idx_d   = '0;
          cnt_d   = '0;
        end
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_d   = '0;
            state_d = (GUARD_CYCLES == 0) ? ON : GUARD;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The frame boundary is the cycle o_frame_done is high, so a load seen then lands in active directly.
  always_comb begin : buffers
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    act_blk_d  = act_blk_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_blk_d = pend_blk_q;
    pend_vld_d = pend_vld_q;
    if (frame_done_q) begin
      pend_vld_d = 1'b0;
      if (i_load) begin
        act_dig_d = i_digits;
        act_dp_d  = i_dp;
        act_blk_d = i_blink_mask;
      end else if (pend_vld_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
        act_blk_d = pend_blk_q;
      end
    end else if (i_load) begin
      pend_dig_d = i_digits;
      pend_dp_d  = i_dp;
      pend_blk_d = i_blink_mask;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin : blink
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_vis_d = blink_vis_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_vis_d = ~blink_vis_q;
    end
  end

  // Uses the next active buffer so digit 0 of a new frame never shows a stale value.
  always_comb begin : digit_sel
    nib      = 4'd0;
    dp_bit   = 1'b0;
    blk_bit  = 1'b0;
    upper_nz = 1'b0;
    an_hot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib       = act_dig_d[4*k +: 4];
        dp_bit    = act_dp_d[k];
        blk_bit   = act_blk_d[k];
        an_hot[k] = 1'b1;
      end
      if (IDX_W'(k) >= idx_q && act_dig_d[4*k +: 4] != 4'd0) begin
        upper_nz = 1'b1;
      end
    end
  end

  seg7_hex_lut u_hex_lut (
    .i_nib (nib),
    .o_seg (lut_seg)
  );

  always_comb begin : out_next
    show         = i_enable && (state_q == ON);
    hide         = (i_blank_lz && (idx_q != '0) && !upper_nz) || (!blink_vis_q && blk_bit);
    seg_al       = (show && !hide) ? lut_seg : SEG_BLANK;
    seg_d        = (SEG_ACT_LOW != 0) ? seg_al : ~seg_al;
    dp_d         = (show && !hide && dp_bit) ^ DP_OFF;
    an_d         = show ? (an_hot ^ AN_OFF) : AN_OFF;
    frame_done_d = wrap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      blink_cnt_q  <= '0;
      blink_vis_q  <= 1'b1;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blk_q    <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blk_q   <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_vis_q  <= blink_vis_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blk_q    <= act_blk_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blk_q   <= pend_blk_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_an         = an_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a 4-digit, 8-clock-slot, 2-clock-guard, 64-clock-blink build.
// Expected per-clock pin words are queued from a reference model and compared as frames are captured.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_digits = '0;
  logic [3:0]  i_dp = '0;
  logic [3:0]  i_blink_mask = '0;
  logic        i_blank_lz = 1'b0;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Captured and expected words are {frame_done, dp, an, seg}.
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .GUARD_CYCLES (2),
    .BLINK_DIV    (64),
    .SEG_ACT_LOW  (1),
    .AN_ACT_LOW   (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (i_enable),
    .i_load       (i_load),
    .i_digits     (i_digits),
    .i_dp         (i_dp),
    .i_blink_mask (i_blink_mask),
    .i_blank_lz   (i_blank_lz),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_an         (o_an),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Queue the 32 pin words of one frame; c0 is the clock count at the sample before the frame starts.
  task automatic push_frame(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] mask,
                            input bit blz, input int c0);
    int hi = 0;
    for (int k = 0; k < 4; k++) if (dig[4*k +: 4] != 4'd0) hi = k;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        int  cs = c0 + 1 + s*8 + c;
        bit  blank;
        logic [3:0] an = 4'hF;
        an[s] = 1'b0;
        if (c < 2) exp_q.push_back({1'b0, 1'b1, 4'hF, 7'h7F});
        else begin
          blank = (blz && s > hi) || (mask[s] && (((cs - 1) / 64) % 2 == 1));
          exp_q.push_back({(s == 3 && c == 7), blank ? 1'b1 : ~dp[s], an,
                           blank ? 7'h7F : hex_tab[dig[4*s +: 4]]});
        end
      end
    end
  endtask

  // Waits (bounded) for a frame_done sample, then captures n following frames.
  task automatic grab_frames(input int n);
    int w = 0;
    while (o_frame_done !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (o_frame_done === 1'b1) begin
      repeat (32*n) begin
        @(negedge clk);
        obs_q.push_back({o_frame_done, o_dp, o_an, o_seg});
      end
    end
  endtask

  task automatic drive_load_at(input int d, input logic [15:0] dig, input logic [3:0] dp,
                               input logic [3:0] mask);
    repeat (d) @(negedge clk);
    i_digits = dig;
    i_dp = dp;
    i_blink_mask = mask;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (o_an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", o_an); end
    checks++; if (o_seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", o_seg); end
    checks++; if (o_dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", o_dp); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_an !== 4'hF) begin errors++; $display("FAIL idle_an got=%b exp=1111", o_an); end
  endtask

  task automatic test_scan();
    int n = 0;
    logic [12:0] e, o;
    drive_load_at(0, 16'h12AF, 4'b0100, 4'b0000);
    i_enable = 1'b1;
    push_frame(16'h12AF, 4'b0100, 4'b0000, 1'b0, 0);
    grab_frames(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL scan[%0d] got=none exp=%h", n, e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL scan[%0d] got=%h exp=%h", n, o, e); end end
      n++;
    end
    obs_q.delete();
  endtask

  task automatic test_midframe_load();
    int n = 0;
    logic [12:0] e, o;
    push_frame(16'h12AF, 4'b0100, 4'b0000, 1'b0, 0);
    push_frame(16'h3456, 4'b0000, 4'b0000, 1'b0, 0);
    fork
      grab_frames(2);
      begin
        drive_load_at(10, 16'h9999, 4'b1111, 4'b0000);
        drive_load_at(8, 16'h3456, 4'b0000, 4'b0000);
      end
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midload[%0d] got=none exp=%h", n, e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL midload[%0d] got=%h exp=%h", n, o, e); end end
      n++;
    end
    obs_q.delete();
  endtask

  task automatic test_lz();
    int n = 0;
    logic [12:0] e, o;
    i_blank_lz = 1'b1;
    push_frame(16'h3456, 4'b0000, 4'b0000, 1'b1, 0);
    push_frame(16'h0030, 4'b0000, 4'b0000, 1'b1, 0);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b1, 0);
    fork
      grab_frames(3);
      begin
        drive_load_at(1, 16'h0030, 4'b0000, 4'b0000);
        drive_load_at(31, 16'h0000, 4'b0000, 4'b0000);
      end
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL lz[%0d] got=none exp=%h", n, e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL lz[%0d] got=%h exp=%h", n, o, e); end end
      n++;
    end
    obs_q.delete();
  endtask

  task automatic test_blink();
    int n = 0;
    int c0;
    logic [12:0] e, o;
    c0 = cyc;
    i_blank_lz = 1'b0;
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, c0);
    for (int f = 1; f < 6; f++) push_frame(16'h12AF, 4'b0001, 4'b0001, 1'b0, c0 + 32*f);
    fork
      grab_frames(6);
      drive_load_at(1, 16'h12AF, 4'b0001, 4'b0001);
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL blink[%0d] got=none exp=%h", n, e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL blink[%0d] got=%h exp=%h", n, o, e); end end
      n++;
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [12:0] e, o;
    push_frame(16'h8765, 4'b0000, 4'b0000, 1'b0, 0);
    push_frame(16'h8765, 4'b0000, 4'b0000, 1'b0, 0);
    fork
      grab_frames(2);
      drive_load_at(0, 16'h8765, 4'b0000, 4'b0000);
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL fdload[%0d] got=none exp=%h", n, e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL fdload[%0d] got=%h exp=%h", n, o, e); end end
      n++;
    end
    obs_q.delete();
  endtask

  task automatic test_enable_drop();
    int n = 0;
    logic [12:0] e, o;
    repeat (21) @(negedge clk);
    checks++; if (o_an !== 4'b1011) begin errors++; $display("FAIL drop_pre_an got=%b exp=1011", o_an); end
    checks++; if (o_seg !== hex_tab[7]) begin errors++; $display("FAIL drop_pre_seg got=%b exp=%b", o_seg, hex_tab[7]); end
    i_enable = 1'b0;
    @(negedge clk);
    checks++; if (o_an !== 4'hF) begin errors++; $display("FAIL drop_an got=%b exp=1111", o_an); end
    checks++; if (o_seg !== 7'h7F) begin errors++; $display("FAIL drop_seg got=%b exp=1111111", o_seg); end
    drive_load_at(2, 16'h4321, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    checks++; if (o_an !== 4'hF) begin errors++; $display("FAIL idle_dark got=%b exp=1111", o_an); end
    // One clock leaving IDLE plus two guard clocks stay dark before digit 0 lights.
    i_enable = 1'b1;
    do begin @(negedge clk); n++; end while (o_an === 4'hF && n < 20);
    checks++; if (n !== 4) begin errors++; $display("FAIL reenable_delay got=%0d exp=4", n); end
    checks++; if (o_an !== 4'b1110) begin errors++; $display("FAIL reenable_an got=%b exp=1110", o_an); end
    checks++; if (o_seg !== hex_tab[5]) begin errors++; $display("FAIL reenable_seg got=%b exp=%b", o_seg, hex_tab[5]); end
    n = 0;
    push_frame(16'h4321, 4'b0000, 4'b0000, 1'b0, 0);
    grab_frames(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL pend_kept[%0d] got=none exp=%h", n, e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL pend_kept[%0d] got=%h exp=%h", n, o, e); end end
      n++;
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_lz();
    test_blink();
    test_back_to_back();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
